regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer.sv | 174 +++++++++++++++++
 tb/tb_regfile_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Sequences one instruction at a time through operand read, execute issue,
// result wait and register-file writeback.
module regfile_sequencer #(
    parameter int RESULT_TIMEOUT = 255
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instruction_i,
    output logic        rf_enable_read_o,
    output logic        rf_enable_write_o,
    output logic [4:0]  rf_address1_o,
    output logic [4:0]  rf_address2_o,
    output logic [31:0] rf_instruction_o,
    output logic [31:0] rf_data_o,
    input  logic [31:0] rf_data_out1_i,
    input  logic [31:0] rf_data_out2_i,
    output logic        op_valid_o,
    input  logic        op_ready_i,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic [4:0]  op_opcode_o,
    input  logic        result_valid_i,
    input  logic [31:0] result_data_i,
    output logic        busy_o,
    output logic        illegal_op_o,
    output logic        timeout_err_o
);

    localparam logic [4:0] OP_SW   = 5'd1;
    localparam logic [4:0] OP_MOV  = 5'd2;
    localparam logic [4:0] OP_CMP  = 5'd11;
    localparam logic [4:0] OP_LAST = 5'd12;
    localparam int CNT_W = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (RESULT_TIMEOUT > 0) ? CNT_W'(RESULT_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE, S_READ1, S_READ2, S_ISSUE, S_WAIT_RES, S_WRITEBACK
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       op_a_q, op_a_d, op_b_q, op_b_d, rf_data_q, rf_data_d;
    logic [4:0]        op_opcode_q, op_opcode_d;
    logic              illegal_d, timeout_d, accept, rd_phase;
    logic [4:0]        opcode_q, opcode_d;

    logic              instr_ready_q, rf_enable_read_q, rf_enable_write_q;
    logic [4:0]        rf_address1_q, rf_address2_q;
    logic [31:0]       rf_instruction_q;
    logic              op_valid_q, busy_q, illegal_q, timeout_q;

    assign opcode_q = instr_q[31:27];
    assign opcode_d = instr_d[31:27];
    assign accept   = instr_ready_q & instr_valid_i;
    assign rd_phase = (state_d == S_READ1) || (state_d == S_READ2);

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_opcode_d = op_opcode_q;
        rf_data_d   = rf_data_q;
        illegal_d   = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    instr_d = instruction_i;
                    if (instruction_i[31:27] <= OP_LAST) state_d = S_READ1;
                    else                                 illegal_d = 1'b1;
                end
            end
            S_READ1: state_d = S_READ2;
            S_READ2: begin
                op_a_d      = rf_data_out1_i;
                op_b_d      = rf_data_out2_i;
                op_opcode_d = opcode_q;
                if (opcode_q == OP_MOV) begin
                    rf_data_d = '0;
                    state_d   = S_WRITEBACK;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_ready_i) begin
                    if (opcode_q == OP_SW || opcode_q == OP_CMP) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_RES;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT_RES: begin
                // A result arriving in the final allowed cycle still wins over the timeout.
                if (result_valid_i) begin
                    rf_data_d = result_data_i;
                    state_d   = S_WRITEBACK;
                end else if (RESULT_TIMEOUT != 0 && cnt_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WRITEBACK: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q           <= S_IDLE;
            instr_q           <= '0;
            cnt_q             <= '0;
            op_a_q            <= '0;
            op_b_q            <= '0;
            op_opcode_q       <= '0;
            rf_data_q         <= '0;
            instr_ready_q     <= 1'b0;
            rf_enable_read_q  <= 1'b0;
            rf_enable_write_q <= 1'b0;
            rf_address1_q     <= '0;
            rf_address2_q     <= '0;
            rf_instruction_q  <= '0;
            op_valid_q        <= 1'b0;
            busy_q            <= 1'b0;
            illegal_q         <= 1'b0;
            timeout_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            instr_q           <= instr_d;
            cnt_q             <= cnt_d;
            op_a_q            <= op_a_d;
            op_b_q            <= op_b_d;
            op_opcode_q       <= op_opcode_d;
            rf_data_q         <= rf_data_d;
            instr_ready_q     <= (state_d == S_IDLE);
            rf_enable_read_q  <= rd_phase;
            rf_enable_write_q <= (state_d == S_WRITEBACK);
            rf_address1_q     <= rd_phase ? ((opcode_d == OP_MOV) ? instr_d[4:0] : instr_d[21:17]) : '0;
            rf_address2_q     <= rd_phase ? instr_d[4:0] : '0;
            rf_instruction_q  <= (state_d != S_IDLE) ? instr_d : '0;
            op_valid_q        <= (state_d == S_ISSUE);
            busy_q            <= (state_d != S_IDLE);
            illegal_q         <= illegal_d;
            timeout_q         <= timeout_d;
        end
    end

    assign instr_ready_o     = instr_ready_q;
    assign rf_enable_read_o  = rf_enable_read_q;
    assign rf_enable_write_o = rf_enable_write_q;
    assign rf_address1_o     = rf_address1_q;
    assign rf_address2_o     = rf_address2_q;
    assign rf_instruction_o  = rf_instruction_q;
    assign rf_data_o         = rf_data_q;
    assign op_valid_o        = op_valid_q;
    assign op_a_o            = op_a_q;
    assign op_b_o            = op_b_q;
    assign op_opcode_o       = op_opcode_q;
    assign busy_o            = busy_q;
    assign illegal_op_o      = illegal_q;
    assign timeout_err_o     = timeout_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: directed table, hand-written
// corner sequences and randomized instructions against a latency/regfile model.
module tb_regfile_sequencer;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instruction = '0;
    logic        rf_enable_read, rf_enable_write;
    logic [4:0]  rf_address1, rf_address2;
    logic [31:0] rf_instruction, rf_data;
    logic [31:0] rf_data_out1, rf_data_out2;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [31:0] op_a, op_b;
    logic [4:0]  op_opcode;
    logic        result_valid = 1'b0;
    logic [31:0] result_data = '0;
    logic        busy, illegal_op, timeout_err;

    logic [31:0] regs     [32];
    logic [31:0] exp_regs [32];

    int n_checks = 0;
    int n_fail   = 0;

    assign rf_data_out1 = regs[rf_address1];
    assign rf_data_out2 = regs[rf_address2];

    always #5 clk = ~clk;

    regfile_sequencer #(.RESULT_TIMEOUT(TMO)) dut (
        .clock_i          (clk),
        .reset_i          (rst),
        .instr_valid_i    (instr_valid),
        .instr_ready_o    (instr_ready),
        .instruction_i    (instruction),
        .rf_enable_read_o (rf_enable_read),
        .rf_enable_write_o(rf_enable_write),
        .rf_address1_o    (rf_address1),
        .rf_address2_o    (rf_address2),
        .rf_instruction_o (rf_instruction),
        .rf_data_o        (rf_data),
        .rf_data_out1_i   (rf_data_out1),
        .rf_data_out2_i   (rf_data_out2),
        .op_valid_o       (op_valid),
        .op_ready_i       (op_ready),
        .op_a_o           (op_a),
        .op_b_o           (op_b),
        .op_opcode_o      (op_opcode),
        .result_valid_i   (result_valid),
        .result_data_i    (result_data),
        .busy_o           (busy),
        .illegal_op_o     (illegal_op),
        .timeout_err_o    (timeout_err)
    );

    typedef struct {
        int          lat, nwr, nill, nto, niss, nrd, nbad;
        logic [31:0] wdata, winstr, oa, ob, res;
        logic [4:0]  oop, a1, a2;
    } obs_t;

    typedef struct {
        logic [4:0] op, rd, rs1, rs2;
        int         r, d, lat, wr, ill, to;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected behaviour from the opcode rules: cycles until instr_ready returns and the side effects.
    function automatic void model(input logic [4:0] op, input int r, input int d,
                                  output int lat, output int wr, output int ill, output int to);
        lat = 0; wr = 0; ill = 0; to = 0;
        if (op > 5'd12) begin
            lat = 1; ill = 1;
        end else if (op == 5'd2) begin
            lat = 4; wr = 1;
        end else if (op == 5'd1 || op == 5'd11) begin
            lat = 4 + r;
        end else if (d < TMO) begin
            lat = 6 + r + d; wr = 1;
        end else begin
            lat = 4 + r + TMO; to = 1;
        end
    endfunction

    // Issues one instruction at a negedge with instr_ready high; op_ready is withheld for r
    // issue cycles and result_valid is given in wait cycle d (0-based).
    task automatic run(input logic [31:0] ins, input int r, input int d, output obs_t o);
        int  wc;
        bit  waiting;
        logic [4:0] op;
        o = '{default: 0};
        op = ins[31:27];
        waiting = 1'b0;
        wc = 0;
        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instruction = $urandom;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            if (rf_enable_read && rf_enable_write) o.nbad++;
            if (rf_enable_read) begin
                o.nrd++; o.a1 = rf_address1; o.a2 = rf_address2;
            end
            if (rf_enable_write) begin
                o.nwr++; o.wdata = rf_data; o.winstr = rf_instruction;
                regs[rf_instruction[26:22]] = rf_data;
            end
            if (illegal_op)  o.nill++;
            if (timeout_err) o.nto++;
            if (op_valid) begin
                if (o.niss == 0) begin
                    o.oa = op_a; o.ob = op_b; o.oop = op_opcode;
                end else if (op_a !== o.oa || op_b !== o.ob || op_opcode !== o.oop) begin
                    o.nbad++;
                end
                o.niss++;
            end
            result_valid = 1'b0;
            if (waiting) begin
                if (wc == d) begin
                    result_valid = 1'b1;
                    result_data  = $urandom;
                    o.res        = result_data;
                    waiting      = 1'b0;
                end
                wc++;
            end
            op_ready = op_valid && (o.niss > r);
            if (op_ready && op != 5'd1 && op != 5'd11) begin
                waiting = 1'b1; wc = 0;
            end
            if (instr_ready) begin
                o.lat = cyc;
                op_ready = 1'b0;
                result_valid = 1'b0;
                break;
            end
            @(negedge clk);
        end
        op_ready = 1'b0;
        result_valid = 1'b0;
    endtask

    task automatic check_obs(input string tag, input logic [31:0] ins, input obs_t o,
                             input int r, input int lat, input int wr, input int ill, input int to);
        logic [4:0]  op, rd, rs1, rs2;
        logic        legal, issued;
        logic [31:0] expd;
        op = ins[31:27]; rd = ins[26:22]; rs1 = ins[21:17]; rs2 = ins[4:0];
        legal  = (op <= 5'd12);
        issued = legal && (op != 5'd2);
        check({tag, "_latency"}, o.lat, lat);
        check({tag, "_writes"}, o.nwr, wr);
        check({tag, "_illegal"}, o.nill, ill);
        check({tag, "_timeout"}, o.nto, to);
        check({tag, "_protocol"}, o.nbad, 0);
        check({tag, "_reads"}, o.nrd, legal ? 2 : 0);
        if (legal) begin
            check({tag, "_addr1"}, 32'(o.a1), 32'((op == 5'd2) ? rs2 : rs1));
            check({tag, "_addr2"}, 32'(o.a2), 32'(rs2));
        end
        if (issued) begin
            check({tag, "_issue_cycles"}, o.niss, r + 1);
            check({tag, "_op_a"}, o.oa, exp_regs[rs1]);
            check({tag, "_op_b"}, o.ob, exp_regs[rs2]);
            check({tag, "_op_opcode"}, 32'(o.oop), 32'(op));
        end else begin
            check({tag, "_issue_cycles"}, o.niss, 0);
        end
        if (wr != 0) begin
            expd = (op == 5'd2) ? 32'd0 : o.res;
            check({tag, "_wdata"}, o.wdata, expd);
            check({tag, "_winstr"}, o.winstr, ins);
            exp_regs[rd] = expd;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [15];
        obs_t        o;
        logic [31:0] ins;
        logic [5:0]  wr_seen;
        int          lat, wr, ill, to, r, d;
        logic [4:0]  op;

        tbl[0]  = '{5'd3,  5'd5,  5'd1,  5'd2,  0, 0, 6,  1, 0, 0};
        tbl[1]  = '{5'd4,  5'd6,  5'd3,  5'd4,  2, 1, 9,  1, 0, 0};
        tbl[2]  = '{5'd5,  5'd7,  5'd8,  5'd9,  0, 3, 9,  1, 0, 0};
        tbl[3]  = '{5'd6,  5'd8,  5'd10, 5'd11, 0, 7, 8,  0, 0, 1};
        tbl[4]  = '{5'd6,  5'd9,  5'd12, 5'd13, 1, 4, 9,  0, 0, 1};
        tbl[5]  = '{5'd1,  5'd10, 5'd14, 5'd15, 3, 0, 7,  0, 0, 0};
        tbl[6]  = '{5'd11, 5'd11, 5'd16, 5'd17, 0, 0, 4,  0, 0, 0};
        tbl[7]  = '{5'd2,  5'd4,  5'd20, 5'd9,  0, 0, 4,  1, 0, 0};
        tbl[8]  = '{5'd13, 5'd12, 5'd1,  5'd2,  0, 0, 1,  0, 1, 0};
        tbl[9]  = '{5'd31, 5'd13, 5'd3,  5'd4,  0, 0, 1,  0, 1, 0};
        tbl[10] = '{5'd0,  5'd14, 5'd5,  5'd6,  0, 2, 8,  1, 0, 0};
        tbl[11] = '{5'd12, 5'd15, 5'd7,  5'd8,  1, 0, 7,  1, 0, 0};
        tbl[12] = '{5'd10, 5'd0,  5'd9,  5'd10, 0, 0, 6,  1, 0, 0};
        tbl[13] = '{5'd8,  5'd16, 5'd11, 5'd12, 2, 3, 11, 1, 0, 0};
        tbl[14] = '{5'd7,  5'd17, 5'd13, 5'd14, 1, 5, 9,  0, 0, 1};

        for (int i = 0; i < 32; i++) begin
            regs[i] = $urandom;
            exp_regs[i] = regs[i];
        end

        // Reset behaviour
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", 32'(|{instr_ready, rf_enable_read, rf_enable_write, rf_address1,
              rf_address2, rf_instruction, rf_data, op_valid, op_a, op_b, op_opcode, busy,
              illegal_op, timeout_err}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_release_ready", 32'(instr_ready), 1);
        check("reset_release_busy", 32'(busy), 0);

        // Minimum-latency ADD with op_ready and result_valid held high
        regs[1] = 32'd7; regs[2] = 32'd3; exp_regs[1] = 32'd7; exp_regs[2] = 32'd3;
        ins = {5'd3, 5'd5, 5'd1, 12'h5a5, 5'd2};
        op_ready = 1'b1; result_valid = 1'b1; result_data = 32'd10;
        instruction = ins; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        wr_seen = '0;
        for (int c = 1; c <= 6; c++) begin
            wr_seen[c-1] = rf_enable_write;
            if (rf_enable_write) regs[rf_instruction[26:22]] = rf_data;
            if (c == 3) begin
                check("add_c3_op_valid", 32'(op_valid), 1);
                check("add_c3_op_a", op_a, 32'd7);
                check("add_c3_op_b", op_b, 32'd3);
                check("add_c3_op_opcode", 32'(op_opcode), 32'd3);
            end
            if (c == 5) begin
                check("add_c5_rf_data", rf_data, 32'd10);
                check("add_c5_rf_instruction", rf_instruction, ins);
            end
            if (c == 6) check("add_c6_instr_ready", 32'(instr_ready), 1);
            else        @(negedge clk);
        end
        check("add_write_cycles", 32'(wr_seen), 32'b010000);
        exp_regs[5] = 32'd10;
        op_ready = 1'b0; result_valid = 1'b0;

        // Reset during WAIT_RES with a result arriving in the same cycle
        ins = {5'd6, 5'd7, 5'd3, 12'h0f0, 5'd4};
        op_ready = 1'b1;
        instruction = ins; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) begin
            check("rst_mid_no_early_write", 32'(rf_enable_write), 0);
            @(negedge clk);
        end
        check("rst_mid_busy_before", 32'(busy), 1);
        rst = 1'b1; result_valid = 1'b1; result_data = 32'hdeadbeef; op_ready = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs_zero", 32'(|{instr_ready, rf_enable_read, rf_enable_write, rf_address1,
              rf_address2, rf_instruction, rf_data, op_valid, op_a, op_b, op_opcode, busy,
              illegal_op, timeout_err}), 0);
        rst = 1'b0; result_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_after", 32'(instr_ready), 1);
        check("rst_mid_no_write_after", 32'(rf_enable_write), 0);
        check("rst_mid_no_timeout", 32'(timeout_err), 0);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            ins = {tbl[i].op, tbl[i].rd, tbl[i].rs1, 12'($urandom), tbl[i].rs2};
            run(ins, tbl[i].r, tbl[i].d, o);
            check_obs($sformatf("tbl%0d", i), ins, o, tbl[i].r, tbl[i].lat, tbl[i].wr,
                      tbl[i].ill, tbl[i].to);
        end

        // Randomized instructions against the model
        for (int i = 0; i < 40; i++) begin
            op = (i % 10 == 9) ? 5'd31 : 5'($urandom_range(0, 15));
            r  = int'($urandom_range(0, 3));
            d  = int'($urandom_range(0, 6));
            ins = {op, 5'($urandom), 5'($urandom), 12'($urandom), 5'($urandom)};
            model(op, r, d, lat, wr, ill, to);
            run(ins, r, d, o);
            check_obs($sformatf("rnd%0d", i), ins, o, r, lat, wr, ill, to);
        end

        for (int i = 0; i < 32; i++)
            check($sformatf("regfile_r%0d", i), regs[i], exp_regs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
